// File: rtl/sap_pkg.sv
// Shared SAP-1 package: bus width, address width and the RAM word type.
// Reused by program_counter, register, alu and sap_ram_16x8.
package sap_pkg;

    localparam int SAP_DATA_W    = 16;
    localparam int SAP_ADDR_W    = 8;
    localparam int SAP_RAM_DEPTH = 16;

    typedef logic [SAP_DATA_W-1:0] ram_word_t;

    typedef enum logic {
        SRC_BUS     = 1'b0,
        SRC_PROGRAM = 1'b1
    } ram_src_e;

endpackage

// File: rtl/sap_ram_array.sv
// Storage array for the SAP RAM: asynchronous clear, one synchronous
// write port, one combinational read port.
module sap_ram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Whole array clears while reset is low; writes land on the rising edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Read port is purely combinational; the caller only uses it in range.
    always_comb begin
        o_rd_data = mem[i_rd_idx];
    end

endmodule

// File: rtl/sap_ram_16x8.sv
// SAP-1 RAM with tri-state bus port, program-load port and address check.
// Optional access trace is compiled in with SAP_RAM_DEBUG_TRACE_EN.
module sap_ram_16x8
    import sap_pkg::*;
#(
    parameter int DATA_W = SAP_DATA_W,
    parameter int DEPTH  = SAP_RAM_DEPTH,
    parameter int ADDR_W = SAP_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_debug,
    input  logic              i_program_mode,
    input  logic [DATA_W-1:0] i_program_data,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_write_enable,
    input  logic              i_read_enable,
    inout  wire  [DATA_W-1:0] io_data,
    output logic [DATA_W-1:0] o_unbuffered,
    output logic              o_addr_error
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              addr_ok;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wr_src;
    logic              wr_en;
    logic [DATA_W-1:0] arr_word;
    logic [DATA_W-1:0] rd_word;

    // Address check: no wrap-around, anything at or above DEPTH is an error.
    always_comb begin
        addr_ok      = (32'(i_address) < 32'(DEPTH));
        o_addr_error = ~addr_ok;
        idx          = i_address[IDX_W-1:0];
    end

    // Write source select and write qualification. In bus mode a read
    // wins over a write so the RAM never captures its own output.
    always_comb begin
        wr_src = (ram_src_e'(i_program_mode) == SRC_PROGRAM) ? i_program_data : io_data;
        wr_en  = i_reset_n & i_write_enable & addr_ok &
                 (i_program_mode | ~i_read_enable);
    end

    sap_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wr_en   (wr_en),
        .i_wr_idx  (idx),
        .i_wr_data (wr_src),
        .i_rd_idx  (idx),
        .o_rd_data (arr_word)
    );

    // Out-of-range addresses and reset both read back as zero.
    always_comb begin
        rd_word      = (addr_ok && i_reset_n) ? arr_word : '0;
        o_unbuffered = rd_word;
    end

    assign io_data = i_read_enable ? rd_word : {DATA_W{1'bz}};

`ifdef SAP_RAM_DEBUG_TRACE_EN
    // Trace each committed write using the values present before the edge.
    always @(posedge i_clk) begin
        if (i_debug && wr_en) begin
            $display("[sap_ram] %0t WRITE addr=%0d data=%h src=%s", $time,
                     i_address, wr_src, i_program_mode ? "program" : "bus");
        end
    end

    // Trace each rising transition of the read enable.
    always @(posedge i_read_enable) begin
        if (i_debug) begin
            $display("[sap_ram] %0t READ  addr=%0d data=%h", $time,
                     i_address, rd_word);
        end
    end
`else
    logic unused_debug;
    assign unused_debug = i_debug;
`endif

endmodule

// File: tb/tb_sap_ram_16x8.sv
module tb_sap_ram_16x8;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_debug;
    logic        i_program_mode;
    logic [15:0] i_program_data;
    logic [7:0]  i_address;
    logic        i_write_enable;
    logic        i_read_enable;
    tri1  [15:0] io_bus;
    logic [15:0] o_unbuffered;
    logic        o_addr_error;

    logic        tb_drv_en;
    logic [15:0] tb_drv;
    assign io_bus = tb_drv_en ? tb_drv : 16'hzzzz;

    int checks = 0;
    int errors = 0;

    // Reference contents of the RAM, maintained from the stimulus.
    logic [15:0] model [16];

    sap_ram_16x8 dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_debug        (i_debug),
        .i_program_mode (i_program_mode),
        .i_program_data (i_program_data),
        .i_address      (i_address),
        .i_write_enable (i_write_enable),
        .i_read_enable  (i_read_enable),
        .io_data        (io_bus),
        .o_unbuffered   (o_unbuffered),
        .o_addr_error   (o_addr_error)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the model and the current inputs.
    function automatic logic [15:0] exp_unbuf();
        if (!i_reset_n || i_address >= 8'd16) return 16'h0000;
        return model[i_address[3:0]];
    endfunction

    function automatic logic [15:0] exp_bus();
        if (i_read_enable) return exp_unbuf();
        if (tb_drv_en) return tb_drv;
        return 16'hFFFF;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    endtask

    // One clock edge; the model commits what the rules say the edge writes.
    task automatic tick();
        bit          commit;
        logic [15:0] wd;
        logic [3:0]  a;
        commit = i_reset_n && i_write_enable && (i_address < 8'd16) &&
                 (i_program_mode || !i_read_enable);
        wd = i_program_mode ? i_program_data : (tb_drv_en ? tb_drv : 16'hFFFF);
        a  = i_address[3:0];
        @(posedge i_clk);
        if (commit) model[a] = wd;
        #1;
    endtask

    task automatic pwrite(input logic [7:0] a, input logic [15:0] d);
        i_program_mode = 1'b1;
        i_address      = a;
        i_program_data = d;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        chk("addr_error", {15'b0, o_addr_error}, {15'b0, (i_address >= 8'd16)});
        chk("unbuffered", o_unbuffered, exp_unbuf());
        chk("bus",        io_bus,       exp_bus());
    end

    initial begin
        clear_model();
        i_reset_n      = 1'b0;
        i_debug        = 1'b1;
        i_program_mode = 1'b1;
        i_program_data = 16'h0;
        i_address      = 8'd0;
        i_write_enable = 1'b0;
        i_read_enable  = 1'b0;
        tb_drv_en      = 1'b0;
        tb_drv         = 16'h0;

        // Reset state, address check still live during reset
        #2;
        chk("rst_unbuf", o_unbuffered, 16'h0000);
        chk("rst_err_lo", {15'b0, o_addr_error}, 16'h0000);
        i_address = 8'h10;
        #1;
        chk("rst_err_hi", {15'b0, o_addr_error}, 16'h0001);
        i_read_enable = 1'b1;
        #1;
        chk("rst_bus_zero", io_bus, 16'h0000);
        i_read_enable = 1'b0;
        i_address     = 8'd0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Program-mode write, read back, then release
        pwrite(8'd0, 16'h00FF);
        i_read_enable = 1'b1;
        #1;
        chk("a0_read", io_bus, 16'h00FF);
        i_read_enable = 1'b0;
        #1;
        chk("a0_hiz", io_bus, 16'hFFFF);

        // Second word, first word undisturbed
        pwrite(8'd1, 16'hC8FF);
        i_read_enable = 1'b1;
        #1;
        chk("a1_read", io_bus, 16'hC8FF);
        i_read_enable = 1'b0;
        i_address     = 8'd0;
        #1;
        chk("a0_unbuf", o_unbuffered, 16'h00FF);

        // Bus-mode write from the bench, then read+write with bus released
        i_program_mode = 1'b0;
        i_address      = 8'd5;
        tb_drv         = 16'h1234;
        tb_drv_en      = 1'b1;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        tb_drv_en      = 1'b0;
        i_read_enable  = 1'b1;
        #1;
        chk("a5_bus_read", io_bus, 16'h1234);
        i_write_enable = 1'b1;
        tick();
        tick();
        i_write_enable = 1'b0;
        chk("a5_no_selfwrite", io_bus, 16'h1234);
        i_read_enable = 1'b0;

        // Out-of-range address
        pwrite(8'h10, 16'hFFFF);
        chk("oor_err", {15'b0, o_addr_error}, 16'h0001);
        chk("oor_unbuf", o_unbuffered, 16'h0000);
        i_read_enable = 1'b1;
        #1;
        chk("oor_bus", io_bus, 16'h0000);
        i_address = 8'd0;
        #1;
        chk("oor_a0_intact", io_bus, 16'h00FF);
        i_read_enable = 1'b0;
        i_address     = 8'hFF;
        #1;
        chk("oor_err_ff", {15'b0, o_addr_error}, 16'h0001);

        // Program mode read+write: old word before the edge, new after
        pwrite(8'd3, 16'h0001);
        i_read_enable  = 1'b1;
        i_program_data = 16'hABCD;
        i_write_enable = 1'b1;
        #1;
        chk("rw_old", io_bus, 16'h0001);
        tick();
        i_write_enable = 1'b0;
        chk("rw_new", io_bus, 16'hABCD);
        i_read_enable = 1'b0;

        // Fill every word, then assert reset mid-cycle
        for (int i = 0; i < 16; i++) begin
            pwrite(8'(i), 16'(16'h1111 * (i + 1)) ^ 16'h8000);
        end
        i_address = 8'd9;
        #1;
        chk("fill_a9", o_unbuffered, 16'h2AAA);
        @(negedge i_clk);
        #1;
        i_read_enable = 1'b1;
        i_reset_n     = 1'b0;
        clear_model();
        #0.1;
        chk("rst_async_a9", io_bus, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            i_address = 8'(i);
            #0.1;
            chk("rst_clear_unbuf", o_unbuffered, 16'h0000);
            chk("rst_clear_bus", io_bus, 16'h0000);
        end
        i_read_enable = 1'b0;

        // Write coincident with reset is lost
        i_address      = 8'd2;
        i_program_data = 16'h5A5A;
        i_write_enable = 1'b1;
        tick();
        i_write_enable = 1'b0;
        chk("rst_write_lost", o_unbuffered, 16'h0000);

        // Normal operation after release
        i_reset_n = 1'b1;
        tick();
        pwrite(8'd2, 16'h5A5A);
        chk("post_rst_write", o_unbuffered, 16'h5A5A);
        pwrite(8'd15, 16'h7E7E);
        chk("top_word", o_unbuffered, 16'h7E7E);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
